// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD bypassed read ports, a per-entry
// pending-write scoreboard, a zero-fill sequencer and a registered debug port.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic [NRD-1:0]          re,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic                    sb_set,
  input  logic [ADDR_W-1:0]       sb_addr,
  input  logic                    clr_req,
  output logic                    init_busy,
  input  logic [ADDR_W-1:0]       dbg_sel,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic        ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic run;
  logic wr0_en;
  logic wr1_en;
  logic init_wr;

  assign run     = (state_q == ST_RUN);
  assign wr0_en  = run && we0 && !(ZERO_EN && (waddr0 == '0));
  assign wr1_en  = run && we1 && !(ZERO_EN && (waddr1 == '0));
  assign init_wr = !run && !(ZERO_EN && (cnt_q == '0));

  // Sequencer: INIT sweeps every entry once, RUN waits for a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Scoreboard: clears on write, set wins over a same-cycle clear, wiped on INIT
  always_comb begin
    busy_d = busy_q;
    if (!run || clr_req) begin
      busy_d = '0;
    end else begin
      if (we0) busy_d[waddr0] = 1'b0;
      if (we1) busy_d[waddr1] = 1'b0;
      if (sb_set) busy_d[sb_addr] = 1'b1;
      if (ZERO_EN) busy_d[0] = 1'b0;
    end
  end

  assign dbg_data_d = (ZERO_EN && (dbg_sel == '0)) ? '0 : mem_q[dbg_sel];

  // Storage has no reset; the INIT sweep defines its contents. Port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (wr0_en) mem_q[waddr0] <= wdata0;
      if (wr1_en) mem_q[waddr1] <= wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      busy_q     <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Read ports with write-through bypass, port 1 taking priority
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    assign ra   = raddr[i*ADDR_W +: ADDR_W];
    assign hit0 = we0 && (waddr0 == ra);
    assign hit1 = we1 && (waddr1 == ra);

    assign rdata[i*DATA_W +: DATA_W] = (!run || !re[i])          ? '0 :
                                       (ZERO_EN && (ra == '0))   ? '0 :
                                       hit1                      ? wdata1 :
                                       hit0                      ? wdata0 :
                                                                   mem_q[ra];
    assign rbusy[i] = run && re[i] && busy_q[ra] && !hit0 && !hit1;
  end

  assign init_busy = (state_q == ST_INIT);
  assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, a reference model with a debug-port
// scoreboard queue, and hand sequences for clear, reset and init-length corners.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int DEP = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR-1:0]     re;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              clr_req;
  logic              init_busy;
  logic [AW-1:0]     dbg_sel;
  logic [DW-1:0]     dbg_data;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req),
    .init_busy(init_busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic          valid;
    logic [DW-1:0] val;
  } dexp_t;
  dexp_t dbg_q[$];

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          sb;
    logic [AW-1:0] sba;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [AW-1:0] dbg;
    logic [DW-1:0] exp_rd0;
    logic          exp_rb0;
  } vec_t;

  // Reference model state
  logic [DW-1:0] m_mem   [DEP];
  bit            m_known [DEP];
  bit            m_busy  [DEP];
  bit            m_init;
  int            m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_rd(input int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    if (m_init || !re[p]) return '0;
    if (a == '0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  function automatic logic m_rb(input int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    return !m_init && re[p] && m_busy[a] && !(we1 && waddr1 == a) && !(we0 && waddr0 == a);
  endfunction

  function automatic void m_update();
    if (m_init) begin
      m_mem[m_cnt]   = '0;
      m_known[m_cnt] = 1'b1;
      if (m_cnt == DEP - 1) m_init = 1'b0;
      m_cnt = (m_cnt + 1) % DEP;
    end else begin
      if (we0 && waddr0 != '0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != '0) m_mem[waddr1] = wdata1;
      if (we0) m_busy[waddr0] = 1'b0;
      if (we1) m_busy[waddr1] = 1'b0;
      if (sb_set && sb_addr != '0) m_busy[sb_addr] = 1'b1;
      if (clr_req) begin
        m_init = 1'b1;
        m_cnt  = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end
    end
  endfunction

  // Compare combinational outputs mid-cycle and queue the debug value due after the edge
  task automatic sample_phase();
    dexp_t d;
    @(negedge clk);
    chk("init_busy", 32'(init_busy), 32'(m_init));
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], m_rd(p));
      chk($sformatf("rbusy%0d", p), 32'(rbusy[p]), 32'(m_rb(p)));
    end
    d.valid = (dbg_sel == '0) || m_known[dbg_sel];
    d.val   = (dbg_sel == '0) ? '0 : m_mem[dbg_sel];
    dbg_q.push_back(d);
  endtask

  task automatic edge_phase();
    dexp_t d;
    @(posedge clk);
    m_update();
    #1;
    if (dbg_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL dbg_queue: got empty expected entry at %0t", $time);
    end else begin
      d = dbg_q.pop_front();
      if (d.valid) chk("dbg_data", dbg_data, d.val);
    end
  endtask

  task automatic tick();
    sample_phase();
    edge_phase();
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    sb_set = 1'b0; sb_addr = '0; clr_req = 1'b0;
  endtask

  task automatic assert_rst();
    rst    = 1'b0;
    m_init = 1'b1;
    m_cnt  = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    dbg_q.delete();
    #1;
    chk("rst_rdata0", rdata[DW-1:0], '0);
    chk("rst_rdata1", rdata[2*DW-1:DW], '0);
    chk("rst_rbusy", 32'(rbusy), '0);
    chk("rst_dbg", dbg_data, '0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_init_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
  endtask

  // Count the cycles init_busy stays high, bounded
  task automatic wait_init(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      sample_phase();
      if (!init_busy) done = 1'b1;
      else n++;
      edge_phase();
    end
    chk(name, 32'(n), 32'd32);
  endtask

  task automatic sweep_zero(input string name);
    idle();
    re = 2'b11;
    for (int a = 0; a < DEP; a++) begin
      raddr   = {AW'(a ^ 1), AW'(a)};
      dbg_sel = AW'(a);
      sample_phase();
      chk(name, rdata[DW-1:0], '0);
      chk({name, "_busy"}, 32'(rbusy), '0);
      edge_phase();
    end
  endtask

  function automatic vec_t mk(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic sb, input logic [AW-1:0] sa, input logic [1:0] r,
                              input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                              input logic [AW-1:0] dbg, input logic [DW-1:0] erd, input logic erb);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.sb = sb; v.sba = sa; v.re = r; v.ra0 = ra0; v.ra1 = ra1; v.dbg = dbg;
    v.exp_rd0 = erd; v.exp_rb0 = erb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 2'b01, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd5, 5'd0, 5'd5, 32'h12345678, 1'b0);
    tbl[2]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd0, 5'd5, 5'd0, 32'h0,        1'b0);
    tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0);
    tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 2'b01, 5'd7, 5'd0, 5'd7, 32'h0,        1'b0);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 5'd7, 32'h0,        1'b1);
    tbl[6]  = mk(1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 5'd7, 32'h77,       1'b0);
    tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 5'd7, 32'h77,       1'b0);
    tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h88,       1'b1, 5'd7, 2'b01, 5'd7, 5'd0, 5'd7, 32'h88,       1'b0);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd7, 5'd0, 5'd7, 32'h88,       1'b1);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b00, 5'd7, 5'd0, 5'd7, 32'h0,        1'b0);
    tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 2'b01, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0);
    tbl[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b01, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0);
    tbl[13] = mk(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 2'b11, 5'd3, 5'd7, 5'd3, 32'hA5A5A5A5, 1'b0);
    tbl[14] = mk(1'b1, 5'd9, 32'h1,        1'b1, 5'd10, 32'h2,       1'b0, 5'd0, 2'b11, 5'd9, 5'd10, 5'd9, 32'h1,       1'b0);

    // Power-up reset and first sweep
    rst = 1'b1;
    idle();
    re = '0; raddr = '0; dbg_sel = '0;
    #1;
    assert_rst();
    release_rst();
    wait_init("boot_init_len");
    sweep_zero("boot_zero");

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      we0 = tbl[i].we0; waddr0 = tbl[i].wa0; wdata0 = tbl[i].wd0;
      we1 = tbl[i].we1; waddr1 = tbl[i].wa1; wdata1 = tbl[i].wd1;
      sb_set = tbl[i].sb; sb_addr = tbl[i].sba; clr_req = 1'b0;
      re = tbl[i].re; raddr = {tbl[i].ra1, tbl[i].ra0}; dbg_sel = tbl[i].dbg;
      sample_phase();
      chk($sformatf("vec%0d_rdata0", i), rdata[DW-1:0], tbl[i].exp_rd0);
      chk($sformatf("vec%0d_rbusy0", i), 32'(rbusy[0]), 32'(tbl[i].exp_rb0));
      edge_phase();
    end

    // Mark r3 pending, then clear the whole file
    idle();
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd3};
    sample_phase();
    chk("r3_pending", 32'(rbusy[0]), 32'd1);
    chk("r3_value", rdata[DW-1:0], 32'hA5A5A5A5);
    clr_req = 1'b1;
    edge_phase();
    clr_req = 1'b0;
    wait_init("clr_init_len");
    sweep_zero("clr_zero");

    // Randomised traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); waddr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
      sb_set = ($urandom_range(0, 3) == 0); sb_addr = AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 63) == 0);
      re = 2'($urandom_range(0, 3));
      raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      dbg_sel = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    for (int k = 0; k < 40 && m_init; k++) tick();

    // Reset in the middle of RUN with live outputs
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFEF00D;
    sb_set = 1'b1; sb_addr = 5'd13;
    tick();
    idle();
    re = 2'b11; raddr = {5'd13, 5'd12}; dbg_sel = 5'd12;
    tick();
    chk("pre_rst_rdata", rdata[DW-1:0], 32'hCAFEF00D);
    chk("pre_rst_rbusy", 32'(rbusy[1]), 32'd1);
    chk("pre_rst_dbg", dbg_data, 32'hCAFEF00D);
    assert_rst();
    release_rst();
    wait_init("rst_run_init_len");

    // Reset at INIT count 10
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    assert_rst();
    release_rst();
    wait_init("rst_init_init_len");
    sweep_zero("final_zero");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have ports in this order:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- we0, we1  in  1 each  write enables, ports 0 and 1.
- waddr0, waddr1  in  ADDR_W each  write addresses.
- wdata0, wdata1  in  DATA_W each  write data.
- re  in  NRD  per-port read enables.
- raddr  in  NRD*ADDR_W  read addresses; port i in bits [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data; same packing as raddr.
- rbusy  out  NRD  per-port scoreboard pending flag.
- sb_set  in  1  mark a register as pending a write.
- sb_addr  in  ADDR_W  register to mark.
- clr_req  in  1  request a full register clear.
- init_busy  out  1  high while the clear sequencer runs.
- dbg_sel  in  ADDR_W  debug read select.
- dbg_data  out  DATA_W  registered debug read data.

Function
REQ-006 SHALL implement a two-state sequencer, INIT and RUN.
REQ-007 SHALL, in INIT, write zero to entry cnt each cycle and increment cnt; from cnt = DEPTH-1, go to RUN on the next edge.
- INIT therefore lasts exactly DEPTH cycles.
REQ-008 SHALL, in RUN with clr_req=1, load cnt=0 and enter INIT on the next edge; clr_req SHALL be ignored during INIT.
REQ-009 SHALL drive init_busy=1 exactly while in INIT.
REQ-010 SHALL ignore we0, we1 and sb_set while in INIT.
REQ-011 SHALL, in RUN, write wdata0 to waddr0 when we0=1, and wdata1 to waddr1 when we1=1, at the edge.
REQ-012 SHALL, when both ports write the same address in one cycle, store wdata1 (port 1 wins).
REQ-013 SHALL never change entry 0 when ZERO_REG=1.
REQ-014 SHALL compute rdata for port i combinationally, first matching rule wins:
- 0 if in INIT or re[i]=0;
- 0 if ZERO_REG=1 and raddr_i=0;
- wdata1 if we1=1 and waddr1=raddr_i;
- wdata0 if we0=1 and waddr0=raddr_i;
- otherwise the stored entry.
REQ-015 SHALL keep one busy bit per entry; at the edge in RUN:
- sb_set=1 sets busy[sb_addr];
- a write on either port clears busy[waddr].
REQ-016 SHALL let set win when set and clear hit the same address in one cycle.
REQ-017 SHALL never set busy[0] when ZERO_REG=1.
REQ-018 SHALL clear all busy bits on entering INIT.
REQ-019 SHALL drive rbusy[i] combinationally as busy[raddr_i] AND re[i] AND NOT (an enabled write to raddr_i this cycle); rbusy SHALL be 0 in INIT.
REQ-020 SHALL register dbg_data from entry dbg_sel every edge with one-cycle latency, with no bypass; it SHALL return 0 for entry 0 when ZERO_REG=1.
REQ-021 SHALL support all read ports, both write ports and the debug port at the same time in every cycle.

Reset
REQ-022 SHALL, while rst=0, immediately force: rdata=0, rbusy=0, dbg_data=0, busy=0, cnt=0, state=INIT, init_busy=1.
REQ-023 SHALL start the INIT sweep at the first rising edge after rst rises; storage contents are undefined until that sweep completes.
REQ-024 SHALL, when rst is asserted mid-INIT or mid-RUN, abort the current operation and restart from REQ-022.

Verification
REQ-025 Release rst, then count edges -> init_busy high for exactly 32 cycles (defaults), then low; all reads return 0.
REQ-026 RUN: we0 writes 0xDEADBEEF to r5 and we1 writes 0x12345678 to r5 in the same cycle; read r5 -> 0x12345678 next cycle; same-cycle read during the write -> bypass value 0x12345678.
REQ-027 Write 0xFFFFFFFF to r0 -> rdata=0 and dbg_data=0 for r0.
REQ-028 sb_set on r7, then read r7 -> rbusy=1. Write r7 with a same-cycle read -> rbusy=0. Write r7 and sb_set r7 in the same cycle -> rbusy=1 on the next cycle.
REQ-029 r3=0xA5A5A5A5 written, then pulse clr_req -> init_busy for 32 cycles; afterwards r3 reads 0 and all busy bits are 0.
REQ-030 Assert rst at INIT cnt=10 -> outputs 0 immediately; after release a full 32-cycle INIT sweep runs again.
